// File: rtl/sha256_pkg.sv
// Shared definitions for the sha256 hasher: word/address widths common to the
// sequencer and the hashing core, the result block size and the sequencer
// state encoding.
package sha256_pkg;

   localparam int WORD_W     = 32;
   localparam int ADDR_W     = 16;
   localparam int HASH_WORDS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WNONCE = 3'd1,
      KICK   = 3'd2,
      WBUSY  = 3'd3,
      WDONE  = 3'd4,
      NEXT   = 3'd5
   } state_t;

endpackage

// File: rtl/sha256_mem_mux.sv
// Combinational select of the single memory port between the sequencer and
// the sha256 core.
//   core_owns_port : 1 selects the core_* port, 0 selects the seq_* port
//   seq_*          : sequencer-side write enable / address / write data
//   core_*         : core-side write enable / address / write data
//   memory_*       : shared memory port
module sha256_mem_mux
   import sha256_pkg::*;
(
   input  logic              core_owns_port,
   input  logic              seq_we,
   input  logic [ADDR_W-1:0] seq_addr,
   input  logic [WORD_W-1:0] seq_wdata,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [WORD_W-1:0] core_wdata,
   output logic              memory_we,
   output logic [ADDR_W-1:0] memory_addr,
   output logic [WORD_W-1:0] memory_write_data
);

   always_comb begin
      if (core_owns_port) begin
         memory_we         = core_we;
         memory_addr       = core_addr;
         memory_write_data = core_wdata;
      end else begin
         memory_we         = seq_we;
         memory_addr       = seq_addr;
         memory_write_data = seq_wdata;
      end
   end

endmodule

// File: rtl/sha256_nonce_sequencer.sv
// Runs one sha256 core over consecutive nonces: for every job it writes the
// nonce into the message buffer, pulses core_start, waits for the core to
// finish and advances the hash result address.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, input_addr, hash_addr, first_nonce, num_nonces : run request
//   done, error, jobs_done : status (idle flag, sticky watchdog, job count)
//   core_*              : control and memory port of the sha256 core
//   memory_*            : the single shared memory port (read data unused here)
module sha256_nonce_sequencer
   import sha256_pkg::*;
#(
   parameter int NONCE_OFFSET = 3,
   parameter int HASH_STRIDE  = HASH_WORDS,
   parameter int WDOG_CYCLES  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] input_addr,
   input  logic [ADDR_W-1:0] hash_addr,
   input  logic [WORD_W-1:0] first_nonce,
   input  logic [15:0]       num_nonces,
   output logic              done,
   output logic              error,
   output logic [15:0]       jobs_done,
   output logic              core_start,
   output logic [ADDR_W-1:0] core_input_addr,
   output logic [ADDR_W-1:0] core_hash_addr,
   input  logic              core_done,
   input  logic              core_memory_we,
   input  logic [ADDR_W-1:0] core_memory_addr,
   input  logic [WORD_W-1:0] core_memory_write_data,
   output logic              memory_clk,
   output logic              memory_we,
   output logic [ADDR_W-1:0] memory_addr,
   output logic [WORD_W-1:0] memory_write_data,
   input  logic [WORD_W-1:0] memory_read_data
);

   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

   state_t            state_q, state_d;
   logic [15:0]       idx_q, idx_d;
   logic [15:0]       count_q, count_d;
   logic [WORD_W-1:0] nonce_q, nonce_d;
   logic [ADDR_W-1:0] cur_hash_q, cur_hash_d;
   logic [ADDR_W-1:0] in_addr_q, in_addr_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              error_q, error_d;
   logic              done_q, done_d;
   logic [15:0]       jobs_done_q, jobs_done_d;
   logic              core_start_q, core_start_d;
   logic [ADDR_W-1:0] core_in_q, core_in_d;
   logic [ADDR_W-1:0] core_hash_q, core_hash_d;
   logic              seq_we_q, seq_we_d;
   logic [ADDR_W-1:0] seq_addr_q, seq_addr_d;
   logic [WORD_W-1:0] seq_wdata_q, seq_wdata_d;
   logic              core_owns_port;
   logic              unused_read_data;

   // Read data goes straight to the core outside this block.
   assign unused_read_data = ^memory_read_data;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      count_d      = count_q;
      nonce_d      = nonce_q;
      cur_hash_d   = cur_hash_q;
      in_addr_d    = in_addr_q;
      wdog_d       = wdog_q;
      error_d      = error_q;
      jobs_done_d  = jobs_done_q;
      core_in_d    = core_in_q;
      core_hash_d  = core_hash_q;
      seq_addr_d   = seq_addr_q;
      seq_wdata_d  = seq_wdata_q;
      seq_we_d     = 1'b0;
      core_start_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               error_d     = 1'b0;
               jobs_done_d = '0;
               if (num_nonces != 16'd0) begin
                  in_addr_d  = input_addr;
                  cur_hash_d = hash_addr;
                  nonce_d    = first_nonce;
                  count_d    = num_nonces;
                  idx_d      = '0;
                  state_d    = WNONCE;
               end
            end
         end
         WNONCE: state_d = KICK;
         KICK: begin
            wdog_d  = '0;
            state_d = WBUSY;
         end
         WBUSY: begin
            // The core must acknowledge start by dropping core_done; if it
            // never does, the run is abandoned.
            if (!core_done) begin
               state_d = WDONE;
            end else begin
               wdog_d = wdog_q + 1'b1;
               if (wdog_d == WDOG_W'(WDOG_CYCLES)) begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WDONE: if (core_done) state_d = NEXT;
         NEXT: begin
            idx_d       = idx_q + 16'd1;
            jobs_done_d = jobs_done_q + 16'd1;
            nonce_d     = nonce_q + 1'b1;
            cur_hash_d  = cur_hash_q + ADDR_W'(HASH_STRIDE);
            state_d     = (idx_d == count_q) ? IDLE : WNONCE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      if (state_d == WNONCE) begin
         seq_we_d    = 1'b1;
         seq_addr_d  = in_addr_d + ADDR_W'(NONCE_OFFSET);
         seq_wdata_d = nonce_d;
      end
      if (state_d == KICK) begin
         core_start_d = 1'b1;
         core_in_d    = in_addr_d;
         core_hash_d  = cur_hash_d;
      end
      done_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         count_q      <= '0;
         nonce_q      <= '0;
         cur_hash_q   <= '0;
         in_addr_q    <= '0;
         wdog_q       <= '0;
         error_q      <= 1'b0;
         done_q       <= 1'b1;
         jobs_done_q  <= '0;
         core_start_q <= 1'b0;
         core_in_q    <= '0;
         core_hash_q  <= '0;
         seq_we_q     <= 1'b0;
         seq_addr_q   <= '0;
         seq_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         count_q      <= count_d;
         nonce_q      <= nonce_d;
         cur_hash_q   <= cur_hash_d;
         in_addr_q    <= in_addr_d;
         wdog_q       <= wdog_d;
         error_q      <= error_d;
         done_q       <= done_d;
         jobs_done_q  <= jobs_done_d;
         core_start_q <= core_start_d;
         core_in_q    <= core_in_d;
         core_hash_q  <= core_hash_d;
         seq_we_q     <= seq_we_d;
         seq_addr_q   <= seq_addr_d;
         seq_wdata_q  <= seq_wdata_d;
      end
   end

   assign core_owns_port = (state_q == WBUSY) || (state_q == WDONE);

   sha256_mem_mux u_mem_mux (
      .core_owns_port    (core_owns_port),
      .seq_we            (seq_we_q),
      .seq_addr          (seq_addr_q),
      .seq_wdata         (seq_wdata_q),
      .core_we           (core_memory_we),
      .core_addr         (core_memory_addr),
      .core_wdata        (core_memory_write_data),
      .memory_we         (memory_we),
      .memory_addr       (memory_addr),
      .memory_write_data (memory_write_data)
   );

   assign memory_clk      = clk;
   assign done            = done_q;
   assign error           = error_q;
   assign jobs_done       = jobs_done_q;
   assign core_start      = core_start_q;
   assign core_input_addr = core_in_q;
   assign core_hash_addr  = core_hash_q;

endmodule
